// File: rtl/phase_gen.sv
// Phase accumulator feeding the waveform ROM: 32-bit NCO accumulator, registered
// phase/select outputs and a valid/ready config port that can defer updates to the next wrap.
module phase_gen #(
  parameter int unsigned             ACC_W       = 32,
  parameter int unsigned             PHASE_W     = 8,
  parameter logic [ACC_W-1:0]        FTW_RESET   = ACC_W'(32'h0100_0000),
  parameter bit                      SYNC_UPDATE = 1'b1
) (
  input  logic               clk,
  input  logic               en,
  input  logic               run,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [PHASE_W-1:0] cfg_off,
  input  logic [1:0]         cfg_sel,
  output logic [PHASE_W-1:0] phase_out,
  output logic [1:0]         sel_out,
  output logic               phase_valid,
  output logic               wrap
);

  typedef enum logic {NORM, PEND} state_t;

  state_t               r_state, w_state_nxt;
  logic [ACC_W-1:0]     r_acc, r_ftw, r_ftw_s;
  logic [PHASE_W-1:0]   r_off, r_off_s;
  logic [1:0]           r_sel, r_sel_s;
  logic                 r_c1;

  logic [ACC_W:0]       w_sum;
  logic                 w_carry;
  logic                 w_accept;
  logic                 w_load_live;
  logic                 w_load_shadow;
  logic                 w_apply_shadow;

  assign w_sum    = {1'b0, r_acc} + {1'b0, r_ftw};
  assign w_carry  = run & w_sum[ACC_W];
  assign w_accept = cfg_valid & cfg_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_live    = 1'b0;
    w_load_shadow  = 1'b0;
    w_apply_shadow = 1'b0;
    cfg_ready      = (r_state == NORM);
    case (r_state)
      NORM: begin
        if (w_accept) begin
          if (!run || !SYNC_UPDATE) begin
            w_load_live = 1'b1;
          end else begin
            w_load_shadow = 1'b1;
            w_state_nxt   = PEND;
          end
        end
      end
      PEND: begin
        // A stalled accumulator would never wrap, so a stall flushes the pending config.
        if (!run || w_carry) begin
          w_apply_shadow = 1'b1;
          w_state_nxt    = NORM;
        end
      end
      default: w_state_nxt = NORM;
    endcase
  end

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      r_state <= NORM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      r_acc   <= '0;
      r_ftw   <= FTW_RESET;
      r_off   <= '0;
      r_sel   <= '0;
      r_ftw_s <= '0;
      r_off_s <= '0;
      r_sel_s <= '0;
    end else begin
      if (run) r_acc <= w_sum[ACC_W-1:0];
      if (w_apply_shadow) begin
        r_ftw <= r_ftw_s;
        r_off <= r_off_s;
        r_sel <= r_sel_s;
      end else if (w_load_live) begin
        r_ftw <= cfg_ftw;
        r_off <= cfg_off;
        r_sel <= cfg_sel;
      end
      if (w_load_shadow) begin
        r_ftw_s <= cfg_ftw;
        r_off_s <= cfg_off;
        r_sel_s <= cfg_sel;
      end
    end
  end

  // Carry goes through two flops so wrap lines up with the first post-wrap phase_out.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      phase_out   <= '0;
      sel_out     <= '0;
      phase_valid <= 1'b0;
      r_c1        <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      phase_out   <= r_acc[ACC_W-1 -: PHASE_W] + r_off;
      sel_out     <= r_sel;
      phase_valid <= run;
      r_c1        <= w_carry;
      wrap        <= r_c1;
    end
  end

endmodule

// File: tb/tb_phase_gen.sv
// Scoreboard bench for phase_gen: one deferred-update and one immediate-update instance
// share stimulus; a cycle-level reference model predicts each instance's outputs.
module tb_phase_gen;

  localparam longint unsigned TWO32 = 64'd1 << 32;

  typedef struct {
    longint unsigned acc;
    longint unsigned ftw;
    int              off;
    int              sel;
    bit              pend;
    longint unsigned ftw_s;
    int              off_s;
    int              sel_s;
    bit              last_carry;
  } mst_t;

  typedef struct {
    int phase;
    int sel;
    int valid;
    int wrap;
    int ready;
  } exp_t;

  logic        clk, en, run, cfg_valid;
  logic [31:0] cfg_ftw;
  logic [7:0]  cfg_off;
  logic [1:0]  cfg_sel;

  logic        rdy_s, pv_s, wr_s, rdy_i, pv_i, wr_i;
  logic [7:0]  ph_s, ph_i;
  logic [1:0]  so_s, so_i;

  int n_tests = 0;
  int n_fail  = 0;

  mst_t ms, mi;
  exp_t q_s[$];
  exp_t q_i[$];

  phase_gen #(.SYNC_UPDATE(1'b1)) u_sync (
    .clk(clk), .en(en), .run(run), .cfg_valid(cfg_valid), .cfg_ready(rdy_s),
    .cfg_ftw(cfg_ftw), .cfg_off(cfg_off), .cfg_sel(cfg_sel),
    .phase_out(ph_s), .sel_out(so_s), .phase_valid(pv_s), .wrap(wr_s)
  );

  phase_gen #(.SYNC_UPDATE(1'b0)) u_imm (
    .clk(clk), .en(en), .run(run), .cfg_valid(cfg_valid), .cfg_ready(rdy_i),
    .cfg_ftw(cfg_ftw), .cfg_off(cfg_off), .cfg_sel(cfg_sel),
    .phase_out(ph_i), .sel_out(so_i), .phase_valid(pv_i), .wrap(wr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic mst_t mreset();
    mst_t m;
    m.acc = 0; m.ftw = 64'h0100_0000; m.off = 0; m.sel = 0; m.pend = 0;
    m.ftw_s = 0; m.off_s = 0; m.sel_s = 0; m.last_carry = 0;
    return m;
  endfunction

  // Outputs after an edge reflect the state before it; config rules applied afterwards.
  task automatic mstep(inout mst_t m, input bit sync, input bit r, input bit v,
                       input logic [31:0] f, input logic [7:0] o, input logic [1:0] s,
                       output exp_t e);
    longint unsigned nxt;
    bit carry;
    nxt   = m.acc + m.ftw;
    carry = r && (nxt >= TWO32);
    e.phase = int'(((m.acc >> 24) + longint'(m.off)) % 256);
    e.sel   = m.sel;
    e.valid = int'(r);
    e.wrap  = int'(m.last_carry);
    m.last_carry = carry;
    if (r) m.acc = nxt % TWO32;
    if (m.pend) begin
      if (!r || carry) begin
        m.ftw = m.ftw_s; m.off = m.off_s; m.sel = m.sel_s; m.pend = 0;
      end
    end else if (v) begin
      if (!r || !sync) begin
        m.ftw = longint'(f); m.off = int'(o); m.sel = int'(s);
      end else begin
        m.ftw_s = longint'(f); m.off_s = int'(o); m.sel_s = int'(s); m.pend = 1;
      end
    end
    e.ready = int'(!m.pend);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      check("sync.phase_out",   int'(ph_s),  e.phase);
      check("sync.sel_out",     int'(so_s),  e.sel);
      check("sync.phase_valid", int'(pv_s),  e.valid);
      check("sync.wrap",        int'(wr_s),  e.wrap);
      check("sync.cfg_ready",   int'(rdy_s), e.ready);
    end
    if (q_i.size() > 0) begin
      e = q_i.pop_front();
      check("imm.phase_out",   int'(ph_i),  e.phase);
      check("imm.sel_out",     int'(so_i),  e.sel);
      check("imm.phase_valid", int'(pv_i),  e.valid);
      check("imm.wrap",        int'(wr_i),  e.wrap);
      check("imm.cfg_ready",   int'(rdy_i), e.ready);
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [31:0] f,
                     input logic [7:0] o, input logic [1:0] s);
    exp_t es, ei;
    run = r; cfg_valid = v; cfg_ftw = f; cfg_off = o; cfg_sel = s;
    mstep(ms, 1'b1, r, v, f, o, s, es);
    mstep(mi, 1'b0, r, v, f, o, s, ei);
    @(posedge clk);
    q_s.push_back(es);
    q_i.push_back(ei);
    #2;
  endtask

  task automatic idle_run(input bit r, input int n);
    for (int k = 0; k < n; k++) cyc(r, 1'b0, 32'h0, 8'h0, 2'b00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".sync.phase_out"}, int'(ph_s), 0);
    check({tag, ".sync.sel_out"},   int'(so_s), 0);
    check({tag, ".sync.valid"},     int'(pv_s), 0);
    check({tag, ".sync.wrap"},      int'(wr_s), 0);
    check({tag, ".sync.ready"},     int'(rdy_s), 1);
    check({tag, ".imm.phase_out"},  int'(ph_i), 0);
    check({tag, ".imm.valid"},      int'(pv_i), 0);
    check({tag, ".imm.ready"},      int'(rdy_i), 1);
  endtask

  initial begin
    logic [31:0] f;
    en = 1'b0; run = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = '0; cfg_off = '0; cfg_sel = '0;
    ms = mreset(); mi = mreset();
    #12;
    check_reset_outputs("reset");
    en = 1'b1;

    // Default FTW: phase walks 0..255 and wraps after 256 edges.
    idle_run(1'b1, 100);
    // Deferred select/FTW change mid-period; the immediate instance applies at once.
    cyc(1'b1, 1'b1, 32'h0200_0000, 8'd0, 2'b11);
    idle_run(1'b1, 170);
    // Offset change mid-run.
    cyc(1'b1, 1'b1, 32'h0200_0000, 8'd64, 2'b11);
    idle_run(1'b1, 140);
    // Stall, then resume.
    idle_run(1'b0, 10);
    idle_run(1'b1, 20);
    // Flush: zero FTW, deferred accept, then a single stalled edge.
    cyc(1'b0, 1'b1, 32'h0, 8'd5, 2'b01);
    idle_run(1'b1, 5);
    cyc(1'b1, 1'b1, 32'h0100_0000, 8'd9, 2'b10);
    idle_run(1'b1, 5);
    idle_run(1'b0, 1);
    idle_run(1'b1, 30);
    // Large FTW wraps on nearly every edge.
    cyc(1'b0, 1'b1, 32'hC000_0001, 8'd0, 2'b00);
    idle_run(1'b1, 12);
    // Reset asserted while a deferred config is pending.
    cyc(1'b0, 1'b1, 32'h0100_0000, 8'd0, 2'b00);
    idle_run(1'b1, 10);
    cyc(1'b1, 1'b1, 32'h0080_0000, 8'd33, 2'b10);
    idle_run(1'b1, 3);
    @(negedge clk); #1;
    en = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    ms = mreset(); mi = mreset();
    @(posedge clk); #2;
    en = 1'b1;
    idle_run(1'b1, 300);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(3))
        0: f = $urandom();
        1: f = $urandom() | 32'h8000_0000;
        2: f = $urandom() & 32'h03FF_FFFF;
        default: f = 32'h0;
      endcase
      cyc(($urandom_range(7) != 0), ($urandom_range(5) == 0), f,
          8'($urandom()), 2'($urandom()));
    end

    @(negedge clk); #1;
    if (q_s.size() != 0 || q_i.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q_s.size(), q_i.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_gen.md
# phase_gen

Phase accumulator (NCO front end) that produces the 8-bit `phase_in` stream and the 2-bit waveform select consumed by the waveform ROM stage. A 32-bit accumulator advances by a frequency tuning word (FTW) every clock while running. The top bits plus a phase offset form the registered phase output. Configuration (FTW, offset, waveform select) is loaded through a valid/ready handshake and can optionally be deferred to the next accumulator wrap, so waveform or frequency changes never glitch mid-period.

## Interface
- `ACC_W`, 32: accumulator width.
- `PHASE_W`, 8: phase output width; must match the ROM address width.
- `FTW_RESET`, 32'h0100_0000: FTW loaded at reset (one phase step per clock).
- `SYNC_UPDATE`, 1: 1 = config accepted while running applies at next wrap; 0 = applies immediately.
- `clk`  in  1  system clock, all logic on rising edge.
- `en`  in  1  asynchronous active-low reset.
- `run`  in  1  accumulate enable, sampled each edge.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted this cycle.
- `cfg_ftw`  in  ACC_W  new tuning word.
- `cfg_off`  in  PHASE_W  new phase offset.
- `cfg_sel`  in  2  new waveform select (00 tri, 01 reverse tri, 10 square, 11 cosine).
- `phase_out`  out  PHASE_W  registered phase to ROM.
- `sel_out`  out  2  registered waveform select to ROM.
- `phase_valid`  out  1  `phase_out` is live.
- `wrap`  out  1  one-cycle pulse aligned with the first post-wrap phase.

## Operation
- Live registers: `ftw`, `off`, `sel`. Shadow registers: `ftw_s`, `off_s`, `sel_s`.
- FSM has two states:
  - NORM: `cfg_ready`=1.
  - PEND: `cfg_ready`=0.
  - `cfg_ready` is a combinational decode of the state.
- Accept occurs on an edge with `cfg_valid` & `cfg_ready`:
  - If `run`=0 or `SYNC_UPDATE`=0: live registers load at that edge, and the state stays NORM.
  - Otherwise: shadow registers load, and the state goes to PEND.
- In PEND:
  - On the first later edge where `run`=1 and `acc`+`ftw` carries out of `ACC_W` bits, `acc` takes the wrapped sum computed with the old `ftw`, the live registers load from the shadow, and the state goes to NORM.
  - A carry at the accept edge itself does not count.
- PEND with `run` sampled 0: the shadow is applied at that edge and the state goes to NORM. This flushes a pending config when `ftw`=0.
- Accumulator: on each edge with `run`=1, `acc` <= (`acc`+`ftw`) mod 2^ACC_W. When `run`=0, `acc` holds.
- `phase_out` <= (`acc`[ACC_W-1 -: PHASE_W] + `off`) mod 2^PHASE_W on every edge. The offset is added after truncation.
- `phase_valid` <= `run` on every edge.
- Carry is registered twice, c1 then `wrap`, so `wrap` aligns with `phase_out` showing the first post-wrap value.
- `sel_out` equals the live `sel`, registered.
- Reset (`en` low, at any time, including during PEND):
  - `acc`=0, `ftw`=`FTW_RESET`, `off`=0, `sel`=00.
  - Shadows cleared, state NORM.
  - `phase_out`=0, `sel_out`=00, `phase_valid`=0, `wrap`=0, c1=0.
  - A pending config is discarded.

## Timing
- Latency from `acc` to `phase_out` is 1 clock.
- Latency from carry to `wrap` is 2 clocks.
- Immediate config: new `ftw` is used in the addition at the next edge. New `off` and `sel` are visible on `phase_out`/`sel_out` one edge after the accept.
- Deferred config: new `sel` and `off` appear on the outputs one edge after the wrap edge, which is the same edge as the `wrap` pulse.
- `cfg_ready` drops in the cycle after a deferred accept and returns in the cycle after the apply.
- `wrap` fires once per carry, including every cycle when the FTW is at least 2^(ACC_W-1) and carries repeatedly. There is no pulse while `run`=0.
- The ROM adds 2 further clocks of output latency; this block does not compensate for it.

## Test plan
- Reset release with FTW=2^24, `run`=1 from edge 1:
  - `phase_out` reads 0, 1, 2 … on successive edges.
  - At the edge where `acc` wraps, `phase_out`=255; on the next edge `phase_out`=0 with `wrap`=1 for exactly one cycle.
- `SYNC_UPDATE`=1 while running, accept `cfg_sel`=11 with `cfg_ftw`=2^25 at `phase_out`=100:
  - `cfg_ready`=0 until the wrap.
  - `sel_out` stays 00 until `wrap`=1, then becomes 11 in the same cycle.
  - `phase_out` then steps 0, 2, 4.
- `SYNC_UPDATE`=0, `cfg_off`=64 accepted mid-run: `phase_out` jumps by 64 (mod 256) one edge later, with `acc` continuing uninterrupted.
- Stall: `run`=0 for 10 cycles:
  - `acc` and `phase_out` hold.
  - `phase_valid`=0 one edge after `run` falls.
  - No `wrap` pulse.
  - Resuming continues from the held phase.
- Flush: FTW=0 while running, deferred accept, then `run`=0 for one edge: the config applies at that edge and `cfg_ready` returns to 1.
- `en` pulsed low during PEND: all outputs are 0 immediately (asynchronous), the FTW reloads to 2^24, and the pending `sel` never appears.
